// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Optional feature macro: PS2_FILTER_EN (8-sample stability filter on the PS/2 clock).
// Ports:
//   CLK100MHZ, RESET          system clock, asynchronous active-high reset
//   TX_DATA, TX_REQ           byte to send and single-cycle request (accepted in idle only)
//   TX_BUSY                   transfer in progress
//   TX_DONE, TX_ERR           one-cycle completion pulses (acknowledged / nack or timeout)
//   PS2_CLK_IN, PS2_DATA_IN   raw asynchronous pin levels
//   PS2_CLK_OE, PS2_DATA_OE   1 pulls the open-drain pin low, 0 releases it
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       CLK100MHZ,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_REQ,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TX_ERR,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE
);

  localparam int CNT_TOP = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_TOP + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  // The transition is taken on the cycle the counter would reach TIMEOUT_CYCLES,
  // so the FAIL cycle lands exactly TIMEOUT_CYCLES after the count was cleared.
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_REL, S_COMPLETE, S_FAIL
  } state_e;

  // Pin synchronizers; idle lines are high, so reset to 1 to avoid a false edge.
  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= PS2_CLK_IN;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= PS2_DATA_IN;
      dat_s2_q <= dat_s1_q;
    end
  end

  logic clk_cur;
`ifdef PS2_FILTER_EN
  // Window is 7 stored samples plus the current one: 8 equal samples to flip.
  logic [6:0] filt_sh_q;
  logic       filt_q;
  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      filt_sh_q <= '1;
      filt_q    <= 1'b1;
    end else begin
      filt_sh_q <= {filt_sh_q[5:0], clk_s2_q};
      if ((filt_sh_q == 7'h00) && !clk_s2_q) begin
        filt_q <= 1'b0;
      end else if ((filt_sh_q == 7'h7f) && clk_s2_q) begin
        filt_q <= 1'b1;
      end
    end
  end
  assign clk_cur = filt_q;
`else
  assign clk_cur = clk_s2_q;
`endif

  logic clk_last_q, fall_q;
  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      clk_last_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_last_q <= clk_cur;
      fall_q     <= clk_last_q & ~clk_cur;
    end
  end

  state_e        state_q;
  logic [9:0]    frame_q;
  logic [3:0]    bit_cnt_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc_d;
  logic          busy_q, done_q, err_q, clk_oe_q, dat_oe_q;
  logic          timeout_hit, nack, go_fail;

  assign cnt_inc_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    timeout_hit = 1'b0;
    case (state_q)
      S_SHIFT, S_ACK: timeout_hit = !fall_q && (cnt_q == TO_LAST);
      S_WAIT_REL:     timeout_hit = !(clk_cur && dat_s2_q) && (cnt_q == TO_LAST);
      default:        timeout_hit = 1'b0;
    endcase
  end

  assign nack    = (state_q == S_ACK) && fall_q && dat_s2_q;
  assign go_fail = timeout_hit | nack;

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          if (TX_REQ) begin
            frame_q   <= {1'b1, ~^TX_DATA, TX_DATA};
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            clk_oe_q  <= 1'b1;
            state_q   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt_q == INH_LAST) begin
            dat_oe_q <= 1'b1;  // start bit, clock still held for the RTS cycle
            state_q  <= S_RTS;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_RTS: begin
          clk_oe_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (fall_q) begin
            dat_oe_q  <= ~frame_q[0];
            frame_q   <= {1'b0, frame_q[9:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            cnt_q     <= '0;
            if (bit_cnt_q == 4'd9) begin
              state_q <= S_ACK;
            end
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_ACK: begin
          if (fall_q) begin
            cnt_q   <= '0;
            state_q <= S_WAIT_REL;  // a high data line is caught by nack below
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_WAIT_REL: begin
          if (clk_cur && dat_s2_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_COMPLETE;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_COMPLETE: state_q <= S_IDLE;
        S_FAIL:     state_q <= S_IDLE;
        default:    state_q <= S_IDLE;
      endcase

      if (go_fail) begin
        state_q  <= S_FAIL;
        err_q    <= 1'b1;
        busy_q   <= 1'b0;
        clk_oe_q <= 1'b0;
        dat_oe_q <= 1'b0;
      end
    end
  end

  assign TX_BUSY     = busy_q;
  assign TX_DONE     = done_q;
  assign TX_ERR      = err_q;
  assign PS2_CLK_OE  = clk_oe_q;
  assign PS2_DATA_OE = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed self-checking bench for ps2_host_tx with a PS/2 device model
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 100;
  localparam int TO  = 5000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_busy, tx_done, tx_err, clk_oe, dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_pin, ps2_dat_pin;

  assign ps2_clk_pin = ~(clk_oe | dev_clk_low);
  assign ps2_dat_pin = ~(dat_oe | dev_dat_low);

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int oe_run   = 0;
  int oe_last_run = 0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .CLK100MHZ  (clk),
    .RESET      (rst),
    .TX_DATA    (tx_data),
    .TX_REQ     (tx_req),
    .TX_BUSY    (tx_busy),
    .TX_DONE    (tx_done),
    .TX_ERR     (tx_err),
    .PS2_CLK_IN (ps2_clk_pin),
    .PS2_DATA_IN(ps2_dat_pin),
    .PS2_CLK_OE (clk_oe),
    .PS2_DATA_OE(dat_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_err === 1'b1) err_cnt++;
    if (clk_oe === 1'b1) begin
      oe_run++;
    end else begin
      if (oe_run != 0) oe_last_run = oe_run;
      oe_run = 0;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    done_cnt = 0;
    err_cnt = 0;
    oe_last_run = 0;
  endtask

  task automatic send_req(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_req = 1'b1;
    @(negedge clk);
    tx_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (tx_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_assert++;
    if (tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_bound: TX_BUSY still %b after %0d cycles, required 0", name, tx_busy, n);
    end
  endtask

  // Device: clocks at an 80-cycle period, samples data on each rising clock,
  // optionally acks, optionally injects a 3-cycle low glitch after sample glitch_after.
  task automatic device(input bit ack_ok, input int glitch_after,
                        output logic [10:0] s, output bit started);
    int n;
    s = '0;
    started = 1'b0;
    n = 0;
    while (!(dat_oe && !clk_oe) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (dat_oe && !clk_oe) started = 1'b1;
    if (started) begin
      wait_cyc(40);
      s[0] = ps2_dat_pin;
      for (int k = 1; k <= 10; k++) begin
        dev_clk_low = 1'b1;
        wait_cyc(40);
        dev_clk_low = 1'b0;
        s[k] = ps2_dat_pin;
        if (k == glitch_after) begin
          wait_cyc(15);
          dev_clk_low = 1'b1;
          wait_cyc(3);
          dev_clk_low = 1'b0;
          wait_cyc(22);
        end else begin
          wait_cyc(40);
        end
      end
      if (ack_ok) dev_dat_low = 1'b1;
      wait_cyc(10);
      dev_clk_low = 1'b1;
      wait_cyc(40);
      dev_clk_low = 1'b0;
      wait_cyc(10);
      dev_dat_low = 1'b0;
      wait_cyc(40);
    end
  endtask

  task automatic test_reset();
    bit bad;
    rst = 1'b1;
    tx_req = 1'b0;
    tx_data = 8'h00;
    wait_cyc(3);
    n_assert++;
    if ({tx_busy, tx_done, tx_err, clk_oe, dat_oe} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_initial: outputs %b, required 00000", {tx_busy, tx_done, tx_err, clk_oe, dat_oe});
    end
    rst = 1'b0;
    wait_cyc(2);
    clear_counts();
    send_req(8'hED);
    wait_cyc(50);
    n_assert++;
    if (clk_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_inhibit_pre: PS2_CLK_OE %b, required 1", clk_oe);
    end
    #2 rst = 1'b1;
    #1;
    n_assert++;
    if ({tx_busy, tx_done, tx_err, clk_oe, dat_oe} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_async: outputs %b, required 00000", {tx_busy, tx_done, tx_err, clk_oe, dat_oe});
    end
    wait_cyc(5);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ({tx_busy, tx_done, tx_err, clk_oe, dat_oe} !== 5'b0) bad = 1'b1;
    end
    n_assert++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stay_idle: outputs became active after release, required all 0");
    end
    n_assert++;
    if (done_cnt + err_cnt != 0) begin
      n_fail++;
      $display("FAIL reset_no_pulse: done %0d err %0d, required 0 and 0", done_cnt, err_cnt);
    end
  endtask

  task automatic test_send_ed();
    logic [10:0] s;
    bit st;
    clear_counts();
    send_req(8'hED);
    n_assert++;
    if ({tx_busy, clk_oe} !== 2'b11) begin
      n_fail++;
      $display("FAIL ed_accept: busy,clk_oe %b, required 11", {tx_busy, clk_oe});
    end
    device(1'b1, -1, s, st);
    n_assert++;
    if (st !== 1'b1) begin
      n_fail++;
      $display("FAIL ed_rts: device saw no request-to-send, required one");
    end
    n_assert++;
    if (s !== 11'b11111011010) begin
      n_fail++;
      $display("FAIL ed_bits: device sampled %b (stop..start), required 11111011010", s);
    end
    wait_idle("ed");
    wait_cyc(5);
    n_assert++;
    if (oe_last_run != INH + 1) begin
      n_fail++;
      $display("FAIL ed_inhibit_len: PS2_CLK_OE high %0d cycles, required %0d", oe_last_run, INH + 1);
    end
    n_assert++;
    if (done_cnt != 1 || err_cnt != 0) begin
      n_fail++;
      $display("FAIL ed_pulses: done %0d err %0d, required 1 and 0", done_cnt, err_cnt);
    end
  endtask

  task automatic test_nack();
    logic [10:0] s;
    bit st;
    clear_counts();
    send_req(8'h00);
    device(1'b0, -1, s, st);
    wait_idle("nack");
    wait_cyc(5);
    n_assert++;
    if (s !== 11'b11000000000) begin
      n_fail++;
      $display("FAIL nack_bits: device sampled %b, required 11000000000", s);
    end
    n_assert++;
    if (s[9] !== 1'b1) begin
      n_fail++;
      $display("FAIL nack_parity: parity sampled %b, required 1", s[9]);
    end
    n_assert++;
    if (err_cnt != 1 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL nack_pulses: err %0d done %0d, required 1 and 0", err_cnt, done_cnt);
    end
    n_assert++;
    if ({tx_busy, clk_oe, dat_oe} !== 3'b000) begin
      n_fail++;
      $display("FAIL nack_release: busy,clk_oe,data_oe %b, required 000", {tx_busy, clk_oe, dat_oe});
    end
  endtask

  task automatic test_timeout();
    int n;
    clear_counts();
    send_req(8'hFF);
    n = 0;
    while (clk_oe && n < 500) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!tx_err && n < 6000) begin
      @(negedge clk);
      n++;
    end
    n_assert++;
    if (n != TO) begin
      n_fail++;
      $display("FAIL timeout_latency: TX_ERR %0d cycles after PS2_CLK_OE fell, required %0d", n, TO);
    end
    n_assert++;
    if ({tx_busy, clk_oe, dat_oe} !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_release: busy,clk_oe,data_oe %b, required 000", {tx_busy, clk_oe, dat_oe});
    end
    wait_cyc(3);
    n_assert++;
    if (err_cnt != 1 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL timeout_pulses: err %0d done %0d, required 1 and 0", err_cnt, done_cnt);
    end
  endtask

  task automatic test_ignore_req();
    logic [10:0] s;
    bit st;
    clear_counts();
    send_req(8'hED);
    fork
      device(1'b1, -1, s, st);
      begin
        wait_cyc(300);
        tx_data = 8'h55;
        tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
      end
    join
    wait_idle("ignore");
    wait_cyc(300);
    n_assert++;
    if (s[8:1] !== 8'hED) begin
      n_fail++;
      $display("FAIL ignore_byte: device received %h, required ed", s[8:1]);
    end
    n_assert++;
    if (done_cnt != 1 || err_cnt != 0) begin
      n_fail++;
      $display("FAIL ignore_pulses: done %0d err %0d, required 1 and 0", done_cnt, err_cnt);
    end
    n_assert++;
    if ({tx_busy, clk_oe} !== 2'b00) begin
      n_fail++;
      $display("FAIL ignore_no_restart: busy,clk_oe %b, required 00", {tx_busy, clk_oe});
    end
  endtask

  task automatic test_glitch();
    logic [10:0] s;
    bit st;
    logic [7:0] exp_byte;
    int exp_done, exp_err;
`ifdef PS2_FILTER_EN
    exp_byte = 8'hED;
    exp_done = 1;
    exp_err  = 0;
`else
    exp_byte = 8'hF5;  // bit 3 skipped by the spurious edge
    exp_done = 0;
    exp_err  = 1;
`endif
    clear_counts();
    send_req(8'hED);
    device(1'b1, 3, s, st);
    wait_idle("glitch");
    wait_cyc(5);
    n_assert++;
    if (s[8:1] !== exp_byte) begin
      n_fail++;
      $display("FAIL glitch_byte: device received %h, required %h", s[8:1], exp_byte);
    end
    n_assert++;
    if (done_cnt != exp_done || err_cnt != exp_err) begin
      n_fail++;
      $display("FAIL glitch_pulses: done %0d err %0d, required %0d and %0d", done_cnt, err_cnt, exp_done, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_nack();
    test_timeout();
    test_ignore_req();
    test_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
